// File: rtl/fix_msg_builder_pkg.sv
// Shared constants for the FIX session message builder: message type codes,
// the MsgType ASCII map, fixed string fragments and their lengths, FSM states.
// Strings are stored first-character-in-MSB; str_byte() returns byte i of one.
package fix_msg_builder_pkg;

  localparam int VALUE_DATA_WIDTH = 64;
  localparam int VALUE_SIZE       = 4;

  localparam logic [3:0] MSG_LOGON      = 4'd1;
  localparam logic [3:0] MSG_LOGOUT     = 4'd2;
  localparam logic [3:0] MSG_HEARTBEAT  = 4'd3;
  localparam logic [3:0] MSG_RESEND_REQ = 4'd4;

  localparam logic [7:0] SOH = 8'h01;

  localparam logic [5:0] BEGIN_LEN        = 6'd10;  // "8=FIX.4.2|"
  localparam logic [5:0] MSGTYPE_LEN      = 6'd5;   // "35=T|"
  localparam logic [5:0] LOGON_EXTRA_LEN  = 6'd12;  // "98=0|108=30|"
  localparam logic [5:0] RESEND_FIXED_LEN = 6'd8;   // "7=" + "|16=0|"
  localparam logic [5:0] RESEND_TAIL_LEN  = 6'd6;   // "|16=0|"
  localparam logic [5:0] TRAILER_LEN      = 6'd7;   // "10=CCC|"
  localparam logic [9:0] BL_FIXED         = 10'd17; // tags/SOHs of 35,49,56,34

  localparam logic [79:0] BEGIN_STR   = {"8=FIX.4.2", SOH};
  localparam logic [95:0] LOGON_STR   = {"98=0", SOH, "108=30", SOH};
  localparam logic [47:0] RESEND_TAIL = {SOH, "16=0", SOH};

  typedef enum logic [3:0] {
    S_IDLE, S_CALC, S_BEGIN, S_BODYLEN, S_MSGTYPE,
    S_SENDER, S_TARGET, S_SEQNUM, S_EXTRA, S_TRAILER
  } state_e;

  function automatic logic known_type(input logic [3:0] c);
    return (c == MSG_LOGON) || (c == MSG_LOGOUT) ||
           (c == MSG_HEARTBEAT) || (c == MSG_RESEND_REQ);
  endfunction

  function automatic logic [7:0] type_ascii(input logic [3:0] c);
    case (c)
      MSG_LOGON:      return "A";
      MSG_LOGOUT:     return "5";
      MSG_HEARTBEAT:  return "0";
      MSG_RESEND_REQ: return "2";
      default:        return "?";
    endcase
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] str_byte(input logic [127:0] s, input logic [5:0] len,
                                          input logic [5:0] i);
    logic [127:0] sh;
    sh = s >> {len - 6'd1 - i, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/fix_msg_builder_bcd_digits.sv
// Purpose: digit count (leading zeros dropped, min 1) and ASCII of emitted digit idx_i.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: bcd_i 8-digit BCD (MS digit in [31:28]), idx_i 0 = first emitted digit,
//        ndig_o 1..8, ascii_o ASCII of the selected digit.
module fix_bcd_digits
  import fix_msg_builder_pkg::*;
(
  input  logic [31:0] bcd_i,
  input  logic [2:0]  idx_i,
  output logic [3:0]  ndig_o,
  output logic [7:0]  ascii_o
);

  logic [2:0]  lz;
  logic        seen;
  logic [2:0]  pos;
  logic [31:0] sh;

  // Only the top seven nibbles can be suppressed; the last digit always prints.
  always_comb begin
    lz   = 3'd0;
    seen = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (!seen && (bcd_i[31-4*k -: 4] == 4'h0)) lz = lz + 3'd1;
      else                                       seen = 1'b1;
    end
  end

  assign ndig_o  = 4'd8 - {1'b0, lz};
  assign pos     = lz + idx_i;
  assign sh      = bcd_i >> {3'd7 - pos, 2'b00};
  assign ascii_o = ascii_digit(sh[3:0]);

endmodule

// File: rtl/fix_msg_builder.sv
// Purpose: serialize a FIX 4.2 session message (header, body, checksum) as a byte stream.
// Latency: request accepted at cycle N, first byte valid at N+2, then one byte/cycle.
// Backpressure: tx_ready_i low holds tx_data_o/tx_last_o; requests while busy are dropped.
// Ports: initiate_msg_i/create_message_i/targetCompId_i/s_v_targetCompId_i/seq_num_i/
//        begin_seq_i request; tx_data_o/tx_valid_o/tx_last_o/tx_ready_i stream; busy_o, drop_o.
module fix_msg_builder
  import fix_msg_builder_pkg::*;
#(
  parameter int                     VALUE_WIDTH = VALUE_DATA_WIDTH,
  parameter int                     SIZE        = VALUE_SIZE,
  parameter logic [VALUE_WIDTH-1:0] SENDER_ID   = VALUE_WIDTH'(32'h5058_4946),
  parameter int                     SENDER_LEN  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   initiate_msg_i,
  input  logic [3:0]             create_message_i,
  input  logic [VALUE_WIDTH-1:0] targetCompId_i,
  input  logic [SIZE-1:0]        s_v_targetCompId_i,
  input  logic [31:0]            seq_num_i,
  input  logic [31:0]            begin_seq_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  output logic                   tx_last_o,
  input  logic                   tx_ready_i,
  output logic                   busy_o,
  output logic                   drop_o
);

  localparam int TMAX = VALUE_WIDTH / 8;

  state_e                 state_q, state_d;
  logic [5:0]             idx_q, idx_d;
  logic [3:0]             type_q, type_d;
  logic [VALUE_WIDTH-1:0] target_q, target_d;
  logic [5:0]             tlen_q, tlen_d;
  logic [31:0]            seq_q, seq_d, beg_q, beg_d;
  logic [9:0]             bl_q, bl_d;
  logic [7:0]             sum_q, sum_d;
  logic                   drop_q, drop_d;

  logic                   hs;
  logic [5:0]             off3, fld_len, extra_len, rs_off, bl_pos;
  logic [3:0]             seq_nd, beg_nd;
  logic [7:0]             seq_chr, beg_chr;
  logic [VALUE_WIDTH-1:0] sender_sh, target_sh;
  logic [3:0]             bl_h, bl_t, bl_o, cs_h, cs_t, cs_o;
  logic [1:0]             bl_nd;
  logic [9:0]             bl_calc;
  logic [5:0]             seq_idx, beg_idx;

  assign tx_valid_o = (state_q != S_IDLE) && (state_q != S_CALC);
  assign busy_o     = (state_q != S_IDLE);
  assign drop_o     = drop_q;
  assign hs         = tx_valid_o && tx_ready_i;

  // Fields with a 3-byte tag ("49=", "56=", "34=") have payload starting at index 3.
  assign off3    = idx_q - 6'd3;
  assign seq_idx = idx_q - 6'd3;
  assign beg_idx = idx_q - 6'd2;
  assign rs_off  = idx_q - 6'd2 - {2'b00, beg_nd};

  fix_bcd_digits u_seq_digits (
    .bcd_i(seq_q), .idx_i(seq_idx[2:0]), .ndig_o(seq_nd), .ascii_o(seq_chr)
  );
  fix_bcd_digits u_beg_digits (
    .bcd_i(beg_q), .idx_i(beg_idx[2:0]), .ndig_o(beg_nd), .ascii_o(beg_chr)
  );

  assign sender_sh = SENDER_ID >> {off3, 3'b000};
  assign target_sh = target_q  >> {off3, 3'b000};

  always_comb begin
    extra_len = 6'd0;
    case (type_q)
      MSG_LOGON:      extra_len = LOGON_EXTRA_LEN;
      MSG_RESEND_REQ: extra_len = RESEND_FIXED_LEN + {2'b00, beg_nd};
      default:        extra_len = 6'd0;
    endcase
  end

  assign bl_calc = BL_FIXED + 10'(SENDER_LEN) + {4'b0, tlen_q} + {6'b0, seq_nd} + {4'b0, extra_len};

  // BodyLength digits; bl_pos maps the emitted digit to hundreds/tens/ones.
  assign bl_h   = 4'(bl_q / 10'd100);
  assign bl_t   = 4'((bl_q / 10'd10) % 10'd10);
  assign bl_o   = 4'(bl_q % 10'd10);
  assign bl_nd  = (bl_q >= 10'd100) ? 2'd3 : ((bl_q >= 10'd10) ? 2'd2 : 2'd1);
  assign bl_pos = idx_q + 6'd1 - {4'b0, bl_nd};

  // Checksum is stable throughout TRAILER since the trailer bytes are not summed.
  assign cs_h = 4'(sum_q / 8'd100);
  assign cs_t = 4'((sum_q / 8'd10) % 8'd10);
  assign cs_o = 4'(sum_q % 8'd10);

  // Current byte and field length, purely from registered state: stable under stall.
  always_comb begin
    tx_data_o = 8'h00;
    tx_last_o = 1'b0;
    fld_len   = 6'd1;
    case (state_q)
      S_BEGIN: begin
        fld_len   = BEGIN_LEN;
        tx_data_o = str_byte(128'(BEGIN_STR), BEGIN_LEN, idx_q);
      end
      S_BODYLEN: begin
        fld_len = 6'd3 + {4'b0, bl_nd};
        if (idx_q == 6'd0)                tx_data_o = "9";
        else if (idx_q == 6'd1)           tx_data_o = "=";
        else if (idx_q == fld_len - 6'd1) tx_data_o = SOH;
        else case (bl_pos[1:0])
          2'd0:    tx_data_o = ascii_digit(bl_h);
          2'd1:    tx_data_o = ascii_digit(bl_t);
          default: tx_data_o = ascii_digit(bl_o);
        endcase
      end
      S_MSGTYPE: begin
        fld_len = MSGTYPE_LEN;
        case (idx_q)
          6'd0:    tx_data_o = "3";
          6'd1:    tx_data_o = "5";
          6'd2:    tx_data_o = "=";
          6'd3:    tx_data_o = type_ascii(type_q);
          default: tx_data_o = SOH;
        endcase
      end
      S_SENDER: begin
        fld_len = 6'd4 + 6'(SENDER_LEN);
        if (idx_q == 6'd0)                tx_data_o = "4";
        else if (idx_q == 6'd1)           tx_data_o = "9";
        else if (idx_q == 6'd2)           tx_data_o = "=";
        else if (idx_q == fld_len - 6'd1) tx_data_o = SOH;
        else                              tx_data_o = sender_sh[7:0];
      end
      S_TARGET: begin
        fld_len = 6'd4 + tlen_q;
        if (idx_q == 6'd0)                tx_data_o = "5";
        else if (idx_q == 6'd1)           tx_data_o = "6";
        else if (idx_q == 6'd2)           tx_data_o = "=";
        else if (idx_q == fld_len - 6'd1) tx_data_o = SOH;
        else                              tx_data_o = target_sh[7:0];
      end
      S_SEQNUM: begin
        fld_len = 6'd4 + {2'b00, seq_nd};
        if (idx_q == 6'd0)                tx_data_o = "3";
        else if (idx_q == 6'd1)           tx_data_o = "4";
        else if (idx_q == 6'd2)           tx_data_o = "=";
        else if (idx_q == fld_len - 6'd1) tx_data_o = SOH;
        else                              tx_data_o = seq_chr;
      end
      S_EXTRA: begin
        fld_len = extra_len;
        if (type_q == MSG_LOGON)                      tx_data_o = str_byte(128'(LOGON_STR), LOGON_EXTRA_LEN, idx_q);
        else if (idx_q == 6'd0)                       tx_data_o = "7";
        else if (idx_q == 6'd1)                       tx_data_o = "=";
        else if (idx_q < 6'd2 + {2'b00, beg_nd})      tx_data_o = beg_chr;
        else                                          tx_data_o = str_byte(128'(RESEND_TAIL), RESEND_TAIL_LEN, rs_off);
      end
      S_TRAILER: begin
        fld_len   = TRAILER_LEN;
        tx_last_o = (idx_q == TRAILER_LEN - 6'd1);
        case (idx_q)
          6'd0:    tx_data_o = "1";
          6'd1:    tx_data_o = "0";
          6'd2:    tx_data_o = "=";
          6'd3:    tx_data_o = ascii_digit(cs_h);
          6'd4:    tx_data_o = ascii_digit(cs_t);
          6'd5:    tx_data_o = ascii_digit(cs_o);
          default: tx_data_o = SOH;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    type_d   = type_q;
    target_d = target_q;
    tlen_d   = tlen_q;
    seq_d    = seq_q;
    beg_d    = beg_q;
    bl_d     = bl_q;
    sum_d    = sum_q;
    drop_d   = initiate_msg_i && ((state_q != S_IDLE) || !known_type(create_message_i));
    case (state_q)
      S_IDLE: begin
        if (initiate_msg_i && known_type(create_message_i)) begin
          type_d   = create_message_i;
          target_d = targetCompId_i;
          tlen_d   = (32'(s_v_targetCompId_i) > 32'(TMAX)) ? 6'(TMAX) : 6'(s_v_targetCompId_i);
          seq_d    = seq_num_i;
          beg_d    = begin_seq_i;
          sum_d    = 8'h00;
          idx_d    = 6'd0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        bl_d    = bl_calc;
        state_d = S_BEGIN;
      end
      default: begin
        if (hs) begin
          if (state_q != S_TRAILER) sum_d = sum_q + tx_data_o;
          if (idx_q == fld_len - 6'd1) begin
            idx_d = 6'd0;
            case (state_q)
              S_BEGIN:   state_d = S_BODYLEN;
              S_BODYLEN: state_d = S_MSGTYPE;
              S_MSGTYPE: state_d = S_SENDER;
              S_SENDER:  state_d = S_TARGET;
              S_TARGET:  state_d = S_SEQNUM;
              S_SEQNUM:  state_d = (extra_len != 6'd0) ? S_EXTRA : S_TRAILER;
              S_EXTRA:   state_d = S_TRAILER;
              default:   state_d = S_IDLE;
            endcase
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      type_q   <= '0;
      target_q <= '0;
      tlen_q   <= '0;
      seq_q    <= '0;
      beg_q    <= '0;
      bl_q     <= '0;
      sum_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      type_q   <= type_d;
      target_q <= target_d;
      tlen_q   <= tlen_d;
      seq_q    <= seq_d;
      beg_q    <= beg_d;
      bl_q     <= bl_d;
      sum_q    <= sum_d;
      drop_q   <= drop_d;
    end
  end

  // BodyLength is emitted with at most three digits.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_CALC)) assert (bl_calc <= 10'd999);
  end

endmodule

// File: tb/tb_fix_msg_builder.sv
`timescale 1ns/1ps
module tb_fix_msg_builder;
  import fix_msg_builder_pkg::*;

  logic        clk;
  logic        rst;
  logic        initiate_msg_i;
  logic [3:0]  create_message_i;
  logic [63:0] targetCompId_i;
  logic [3:0]  s_v_targetCompId_i;
  logic [31:0] seq_num_i;
  logic [31:0] begin_seq_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_last_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        drop_o;

  fix_msg_builder dut (
    .clk(clk), .rst(rst),
    .initiate_msg_i(initiate_msg_i), .create_message_i(create_message_i),
    .targetCompId_i(targetCompId_i), .s_v_targetCompId_i(s_v_targetCompId_i),
    .seq_num_i(seq_num_i), .begin_seq_i(begin_seq_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_last_o(tx_last_o),
    .tx_ready_i(tx_ready_i), .busy_o(busy_o), .drop_o(drop_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         rand_ready = 1'b0;
  int         hs_cnt = 0;
  int         valid_cycles = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // Reference: whole message as text with '|' for SOH, built from the field rules.
  // BCD values print as decimal via %h; BodyLength is simply the body's length.
  function automatic string model_msg(input logic [3:0] t, input string tgt,
                                      input logic [31:0] seq, input logic [31:0] beg);
    string typ, extra, body, head, all_s;
    int    sum;
    typ = "?";
    extra = "";
    case (t)
      MSG_LOGON:      begin typ = "A"; extra = "98=0|108=30|"; end
      MSG_LOGOUT:     typ = "5";
      MSG_HEARTBEAT:  typ = "0";
      MSG_RESEND_REQ: begin typ = "2"; extra = {"7=", $sformatf("%0h", beg), "|16=0|"}; end
      default:        typ = "?";
    endcase
    body  = {"35=", typ, "|49=FIXP|56=", tgt, "|34=", $sformatf("%0h", seq), "|", extra};
    head  = {"8=FIX.4.2|9=", $sformatf("%0d", body.len()), "|"};
    all_s = {head, body};
    sum = 0;
    for (int i = 0; i < all_s.len(); i++)
      sum += (all_s[i] == "|") ? 1 : int'(all_s[i]);
    return {all_s, "10=", $sformatf("%03d", sum % 256), "|"};
  endfunction

  function automatic logic [63:0] pack_tgt(input string s);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < s.len() && i < 8; i++) v[8*i +: 8] = s[i];
    return v;
  endfunction

  // Compare process: every valid cycle against the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", tx_valid_o, 1);
        chk("stall_data_stable", tx_data_o, prev_data);
        chk("stall_last_stable", tx_last_o, prev_last);
      end
      if (tx_valid_o) begin
        valid_cycles++;
        chk("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("tx_data", tx_data_o, exp_q[0]);
          chk("tx_last", tx_last_o, exp_q.size() == 1);
          if (tx_ready_i) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_data  = tx_data_o;
      prev_last  = tx_last_o;
    end
  end

  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [3:0] t, input string tgt, input logic [31:0] seq,
                      input logic [31:0] beg, output int len);
    string m;
    m = model_msg(t, tgt, seq, beg);
    len = m.len();
    @(posedge clk); #1;
    for (int i = 0; i < m.len(); i++) exp_q.push_back((m[i] == "|") ? SOH : m[i]);
    create_message_i   = t;
    targetCompId_i     = pack_tgt(tgt);
    s_v_targetCompId_i = 4'(tgt.len());
    seq_num_i          = seq;
    begin_seq_i        = beg;
    initiate_msg_i     = 1'b1;
    @(posedge clk); #1;
    initiate_msg_i = 1'b0;
    hs_cnt         = 0;
    valid_cycles   = 0;
    @(negedge clk);
    chk("busy_after_accept", busy_o, 1);
    chk("no_valid_in_calc", tx_valid_o, 0);
    @(negedge clk);
    chk("first_byte_at_n_plus_2", tx_valid_o, 1);
  endtask

  task automatic wait_idle(input int len);
    int n;
    n = 0;
    while (busy_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", n < 2000, 1);
    chk("all_bytes_emitted", exp_q.size(), 0);
    if (!rand_ready) chk("no_bubble_cycles", valid_cycles, len);
    exp_q.delete();
  endtask

  task automatic pulse_req(input logic [3:0] t);
    @(posedge clk); #1;
    create_message_i = t;
    initiate_msg_i   = 1'b1;
    @(posedge clk); #1;
    initiate_msg_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_bcd();
    logic [31:0] v;
    int nz;
    v = '0;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    nz = $urandom_range(0, 8);
    for (int i = 0; i < nz; i++) v[31-4*i -: 4] = 4'h0;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    len, n, tl;
    string m, tgt;
    logic [3:0] types [4];
    types[0] = MSG_LOGON; types[1] = MSG_LOGOUT; types[2] = MSG_HEARTBEAT; types[3] = MSG_RESEND_REQ;

    rst = 1'b1; initiate_msg_i = 1'b0; create_message_i = '0; targetCompId_i = '0;
    s_v_targetCompId_i = '0; seq_num_i = '0; begin_seq_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx_valid", tx_valid_o, 0);
    chk("reset_tx_data", tx_data_o, 0);
    chk("reset_tx_last", tx_last_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_drop", drop_o, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Hand-computed pins for the model itself.
    m = model_msg(MSG_HEARTBEAT, "BRK", 32'h7, 32'h0);
    chk_str("model_heartbeat", m, "8=FIX.4.2|9=25|35=0|49=FIXP|56=BRK|34=7|10=025|");
    chk("model_heartbeat_len", m.len(), 47);
    m = model_msg(MSG_LOGON, "BRK", 32'h1, 32'h0);
    chk_str("model_logon", m.substr(0, m.len() - 5), "8=FIX.4.2|9=37|35=A|49=FIXP|56=BRK|34=1|98=0|108=30|10=");
    m = model_msg(MSG_RESEND_REQ, "BRK", 32'h120, 32'h95);
    chk_str("model_resend", m.substr(0, m.len() - 5), "8=FIX.4.2|9=37|35=2|49=FIXP|56=BRK|34=120|7=95|16=0|10=");

    // Directed messages, ready held high.
    rand_ready = 1'b0;
    send(MSG_HEARTBEAT, "BRK", 32'h7, 32'h0, len);       wait_idle(len);
    send(MSG_LOGON, "BRK", 32'h1, 32'h0, len);           wait_idle(len);
    send(MSG_RESEND_REQ, "BRK", 32'h120, 32'h95, len);   wait_idle(len);
    send(MSG_LOGOUT, "", 32'h0, 32'h0, len);             wait_idle(len);

    // Random backpressure on the heartbeat case.
    rand_ready = 1'b1;
    send(MSG_HEARTBEAT, "BRK", 32'h7, 32'h0, len);       wait_idle(len);

    // Refusals: request during busy, then unknown type while idle.
    rand_ready = 1'b0;
    send(MSG_HEARTBEAT, "BRK", 32'h7, 32'h0, len);
    pulse_req(MSG_LOGON);
    @(negedge clk);
    chk("drop_when_busy", drop_o, 1);
    @(negedge clk);
    chk("drop_single_cycle_busy", drop_o, 0);
    wait_idle(len);
    pulse_req(4'hF);
    @(negedge clk);
    chk("drop_unknown_type", drop_o, 1);
    chk("unknown_type_not_busy", busy_o, 0);
    @(negedge clk);
    chk("drop_single_cycle_unknown", drop_o, 0);
    chk("unknown_type_still_idle", busy_o, 0);

    // Reset in the middle of a logon, then a clean heartbeat.
    send(MSG_LOGON, "BRK", 32'h1, 32'h0, len);
    n = 0;
    while (hs_cnt < 20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_byte_20", hs_cnt >= 20, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx_valid", tx_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    send(MSG_HEARTBEAT, "BRK", 32'h7, 32'h0, len);       wait_idle(len);

    // Randomized messages.
    for (int r = 0; r < 25; r++) begin
      tgt = "";
      tl  = $urandom_range(0, 8);
      for (int i = 0; i < tl; i++) tgt = $sformatf("%s%c", tgt, 8'($urandom_range(65, 90)));
      rand_ready = 1'($urandom_range(0, 1));
      send(types[$urandom_range(0, 3)], tgt, rand_bcd(), rand_bcd(), len);
      wait_idle(len);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
